bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder_if.sv | 31 +++
 rtl/bit_serial_adder.sv | 123 ++++++++++++
 tb/tb_bit_serial_adder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_if
// Request/result bundle for bit_serial_adder.
//   master (requester) drives : start, a, b, c0, sub
//   slave  (adder)     drives : busy, done, s, c, ovf
// WIDTH must match the WIDTH of the adder this bundle is connected to.
// ---------------------------------------------------------------------------
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c0;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output start, a, b, c0, sub,
        input  busy, done, s, c, ovf
    );

    modport slave (
        input  start, a, b, c0, sub,
        output busy, done, s, c, ovf
    );
endinterface

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
// Multi-cycle WIDTH-bit adder/subtractor. One BITS_PER_CYCLE-wide ripple
// slice is reused for K = WIDTH/BITS_PER_CYCLE cycles, least significant
// digit first.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   rst_n  synchronous active-low reset
//   bus    slave side of bit_serial_adder_if:
//            start/a/b/c0/sub  request, sampled only on the accepting edge
//            busy              operation in flight (exactly K cycles)
//            done              one-cycle pulse, s/c/ovf freshly updated
//            s/c/ovf           result, carry-out (not-borrow when
//                              subtracting) and signed overflow; held
//                              until the next completion or reset
// ---------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bit_serial_adder_if.slave  bus
);

    localparam int K     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(K + 1);

    if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_check
        $error("bit_serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] s_reg;
    logic             c_reg;
    logic             ovf_reg;

    logic [BITS_PER_CYCLE-1:0] digit_sum;
    logic                      carry_v;
    logic                      carry_into_top;
    logic                      slice_carry;
    logic [WIDTH-1:0]          sum_next;

    // Ripple slice over the low digit. carry_into_top is the carry entering
    // the slice's top bit; on the last digit that bit is the word MSB, which
    // is what the overflow flag needs.
    always_comb begin
        digit_sum      = '0;
        carry_v        = carry_reg;
        carry_into_top = carry_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            carry_into_top = carry_v;
            digit_sum[i]   = a_reg[i] ^ b_reg[i] ^ carry_v;
            carry_v        = (a_reg[i] & b_reg[i]) | (carry_v & (a_reg[i] ^ b_reg[i]));
        end
        slice_carry = carry_v;
    end

    // New digit enters at the MSB end; after K shifts the first digit has
    // reached bit 0. Written as a shifted concat so it also holds when K == 1.
    assign sum_next = WIDTH'({digit_sum, acc_reg} >> BITS_PER_CYCLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            s_reg     <= '0;
            c_reg     <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + ~c0: invert once at load
                        // so the slice itself is a plain adder.
                        a_reg     <= bus.a;
                        b_reg     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_reg <= bus.c0 ^ bus.sub;
                        cnt_reg   <= CNT_W'(K);
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> BITS_PER_CYCLE;
                    b_reg     <= b_reg >> BITS_PER_CYCLE;
                    acc_reg   <= sum_next;
                    carry_reg <= slice_carry;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        s_reg     <= sum_next;
                        c_reg     <= slice_carry;
                        ovf_reg   <= carry_into_top ^ slice_carry;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.s    = s_reg;
    assign bus.c    = c_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
// 8-bit / 1-bit-per-cycle instance: directed vector table plus handshake and
// reset sequences. Three 4-bit instances (1, 2, 4 bits per cycle) share one
// stimulus and are swept over every a, b, c0, sub against a reference model.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    bit_serial_adder_if #(.WIDTH(8)) bus8();
    bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    logic       st4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       c04;
    logic       sub4;

    bit_serial_adder_if #(.WIDTH(4)) bus41();
    bit_serial_adder_if #(.WIDTH(4)) bus42();
    bit_serial_adder_if #(.WIDTH(4)) bus44();

    assign bus41.start = st4;  assign bus41.a = a4;  assign bus41.b = b4;
    assign bus41.c0 = c04;     assign bus41.sub = sub4;
    assign bus42.start = st4;  assign bus42.a = a4;  assign bus42.b = b4;
    assign bus42.c0 = c04;     assign bus42.sub = sub4;
    assign bus44.start = st4;  assign bus44.a = a4;  assign bus44.b = b4;
    assign bus44.c0 = c04;     assign bus44.sub = sub4;

    bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(bus41));
    bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut42 (.clk(clk), .rst_n(rst_n), .bus(bus42));
    bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c0;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: {ovf, c, s[7:0]} for a w-bit operation, derived from integer
    // arithmetic (unsigned range for c, signed range for ovf).
    function automatic logic [9:0] model(input int w, input int ia, input int ib,
                                         input int ic, input int is);
        int m, t, s, c, sa, sb, st, o;
        m = 1 << w;
        if (is == 0) begin
            t = ia + ib + ic;
            s = t % m;
            c = (t >= m) ? 1 : 0;
        end else begin
            t = ia - ib - ic;
            s = (t + m) % m;
            c = (t >= 0) ? 1 : 0;
        end
        sa = (ia >= m / 2) ? ia - m : ia;
        sb = (ib >= m / 2) ? ib - m : ib;
        st = (is == 0) ? sa + sb + ic : sa - sb - ic;
        o  = ((st < -(m / 2)) || (st > (m / 2) - 1)) ? 1 : 0;
        return {o[0], c[0], s[7:0]};
    endfunction

    // One 8-bit operation. Operands are scrambled right after acceptance to
    // show they are not sampled again. lat = edges from accept to done.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc0,
                       input logic tsub, output int lat, output int busy_cnt);
        @(negedge clk);
        bus8.a = ta; bus8.b = tb; bus8.c0 = tc0; bus8.sub = tsub; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a = ~ta; bus8.b = ~tb; bus8.c0 = ~tc0; bus8.sub = ~tsub;
        lat = 0;
        busy_cnt = bus8.busy ? 1 : 0;
        while (!bus8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat, busy_cnt, lat1, lat2, lat4, done_cnt;
        logic [9:0] e;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c0 = 1'b0; bus8.sub = 1'b0;
        st4 = 1'b0; a4 = '0; b4 = '0; c04 = 1'b0; sub4 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy8", 32'(bus8.busy), 32'd0);
        check("reset done8", 32'(bus8.done), 32'd0);
        check("reset s8",    32'(bus8.s),    32'd0);
        check("reset c8",    32'(bus8.c),    32'd0);
        check("reset ovf8",  32'(bus8.ovf),  32'd0);
        check("reset busy4", 32'({bus41.busy, bus42.busy, bus44.busy}), 32'd0);
        check("reset s4",    32'({bus41.s, bus42.s, bus44.s}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub, lat, busy_cnt);
            $display("vec %0d: a=%02h b=%02h c0=%0d sub=%0d -> s=%02h c=%0d ovf=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].sub,
                     bus8.s, bus8.c, bus8.ovf, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 32'd8);
            check($sformatf("vec%0d s", i), 32'(bus8.s), 32'(vecs[i].s));
            check($sformatf("vec%0d c", i), 32'(bus8.c), 32'(vecs[i].c));
            check($sformatf("vec%0d ovf", i), 32'(bus8.ovf), 32'(vecs[i].ovf));
        end

        // Start during busy cycle 3 must be ignored
        @(negedge clk);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.c0 = 1'b0; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); lat++; end
        @(negedge clk);
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.c0 = 1'b1; bus8.sub = 1'b1; bus8.start = 1'b1;
        @(posedge clk); #1;
        lat++;
        bus8.start = 1'b0;
        while (!bus8.done && lat < 40) begin @(posedge clk); #1; lat++; end
        $display("ignored start: s=%02h c=%0d ovf=%0d lat=%0d", bus8.s, bus8.c, bus8.ovf, lat);
        check("ignore latency", 32'(lat), 32'd8);
        check("ignore s", 32'(bus8.s), 32'h46);
        check("ignore c", 32'(bus8.c), 32'd0);
        check("ignore ovf", 32'(bus8.ovf), 32'd0);

        // Start in the done cycle: accepted, second done K+1 edges later
        op8(8'h7F, 8'h01, 1'b0, 1'b0, lat, busy_cnt);
        check("b2b first s", 32'(bus8.s), 32'h80);
        check("b2b first ovf", 32'(bus8.ovf), 32'd1);
        bus8.a = 8'h80; bus8.b = 8'h01; bus8.c0 = 1'b0; bus8.sub = 1'b1; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 40) begin @(posedge clk); #1; lat++; end
        $display("back-to-back: s=%02h c=%0d ovf=%0d gap=%0d", bus8.s, bus8.c, bus8.ovf, lat);
        check("b2b gap", 32'(lat), 32'd9);
        check("b2b second s", 32'(bus8.s), 32'h7F);
        check("b2b second c", 32'(bus8.c), 32'd1);
        check("b2b second ovf", 32'(bus8.ovf), 32'd1);

        // Reset at RUN cycle 3
        @(negedge clk);
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.c0 = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("mid-run reset: busy=%0d done=%0d s=%02h c=%0d ovf=%0d",
                 bus8.busy, bus8.done, bus8.s, bus8.c, bus8.ovf);
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst s", 32'(bus8.s), 32'd0);
        check("rst c", 32'(bus8.c), 32'd0);
        check("rst ovf", 32'(bus8.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (12) begin @(posedge clk); #1; if (bus8.done) done_cnt++; end
        check("rst no done", 32'(done_cnt), 32'd0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, busy_cnt);
        $display("after reset: s=%02h c=%0d ovf=%0d lat=%0d", bus8.s, bus8.c, bus8.ovf, lat);
        check("post-rst latency", 32'(lat), 32'd8);
        check("post-rst s", 32'(bus8.s), 32'h00);
        check("post-rst c", 32'(bus8.c), 32'd1);

        // 4-bit exhaustive sweep on all three slice widths
        for (int is = 0; is < 2; is++) begin
            for (int ic = 0; ic < 2; ic++) begin
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        @(negedge clk);
                        a4 = ia[3:0]; b4 = ib[3:0]; c04 = ic[0]; sub4 = is[0]; st4 = 1'b1;
                        @(posedge clk); #1;
                        st4 = 1'b0; a4 = ~a4; b4 = ~b4; c04 = ~c04; sub4 = ~sub4;
                        lat1 = 0; lat2 = 0; lat4 = 0;
                        for (int n = 1; n <= 5; n++) begin
                            @(posedge clk); #1;
                            if (bus41.done && lat1 == 0) lat1 = n;
                            if (bus42.done && lat2 == 0) lat2 = n;
                            if (bus44.done && lat4 == 0) lat4 = n;
                        end
                        e = model(4, ia, ib, ic, is);
                        $display("sweep a=%0h b=%0h c0=%0d sub=%0d exp=%0h/%0d/%0d got1=%0h/%0d/%0d got2=%0h/%0d/%0d got4=%0h/%0d/%0d",
                                 ia, ib, ic, is, e[3:0], e[8], e[9],
                                 bus41.s, bus41.c, bus41.ovf, bus42.s, bus42.c, bus42.ovf,
                                 bus44.s, bus44.c, bus44.ovf);
                        check($sformatf("sweep lat bpc1 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'(lat1), 32'd4);
                        check($sformatf("sweep lat bpc2 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'(lat2), 32'd2);
                        check($sformatf("sweep lat bpc4 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'(lat4), 32'd1);
                        check($sformatf("sweep res bpc1 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'({bus41.ovf, bus41.c, bus41.s}), 32'({e[9], e[8], e[3:0]}));
                        check($sformatf("sweep res bpc2 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'({bus42.ovf, bus42.c, bus42.s}), 32'({e[9], e[8], e[3:0]}));
                        check($sformatf("sweep res bpc4 a=%0h b=%0h c0=%0d sub=%0d", ia, ib, ic, is),
                              32'({bus44.ovf, bus44.c, bus44.s}), 32'({e[9], e[8], e[3:0]}));
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
